// File: rtl/octavo_io_port_fifo.sv
// ---------------------------------------------------------------------------
// octavo_io_port_fifo
//
// Buffering stage outside one Octavo I/O port pair. It has two independent
// FIFOs:
//   read FIFO  : external valid/ready producer -> Octavo read port
//   write FIFO : Octavo write port -> external valid/ready consumer
//
// Ports
//   clock, reset_n                 single clock, asynchronous active-low reset
//   in_valid, in_data, in_ready    producer side of the read FIFO
//   io_read_EF, io_read_data       Octavo read port (EF=1: data available)
//   io_rden                        Octavo pops the read FIFO head
//   io_write_EF                    Octavo write port (EF=1: space available)
//   io_write_data, io_wren         Octavo pushes into the write FIFO
//   out_valid, out_data, out_ready consumer side of the write FIFO
//   read_count, write_count        occupancy (only with the macro below)
//   err_clear                      synchronous clear of the sticky flags
//   underflow, overflow            sticky error flags (Octavo contract broken)
//
// Optional feature: define OCTAVO_IO_PORT_FIFO_COUNT_EN to add the registered
// read_count/write_count occupancy outputs.
//
// Every output comes from a register (pointer, flag, count or storage word);
// no input reaches an output combinationally.
// ---------------------------------------------------------------------------
module octavo_io_port_fifo #(
   parameter int WORD_WIDTH = 36,
   parameter int DEPTH      = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  in_valid,
   input  logic [WORD_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  io_read_EF,
   output logic [WORD_WIDTH-1:0] io_read_data,
   input  logic                  io_rden,
   output logic                  io_write_EF,
   input  logic [WORD_WIDTH-1:0] io_write_data,
   input  logic                  io_wren,
   output logic                  out_valid,
   output logic [WORD_WIDTH-1:0] out_data,
   input  logic                  out_ready,
`ifdef OCTAVO_IO_PORT_FIFO_COUNT_EN
   output logic [ADDR_WIDTH:0]   read_count,
   output logic [ADDR_WIDTH:0]   write_count,
`endif
   input  logic                  err_clear,
   output logic                  underflow,
   output logic                  overflow
);

   localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH+1)'(1);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [ADDR_WIDTH:0]   rf_wptr, rf_rptr, wf_wptr, wf_rptr;
   logic [ADDR_WIDTH:0]   rf_wptr_nxt, rf_rptr_nxt, wf_wptr_nxt, wf_rptr_nxt;
   logic [WORD_WIDTH-1:0] rf_mem [DEPTH];
   logic [WORD_WIDTH-1:0] wf_mem [DEPTH];

   logic rf_empty, rf_full, wf_empty, wf_full;
   logic rf_push, rf_pop, wf_push, wf_pop;

   assign rf_empty = (rf_wptr == rf_rptr);
   assign rf_full  = (rf_wptr[ADDR_WIDTH-1:0] == rf_rptr[ADDR_WIDTH-1:0]) &&
                     (rf_wptr[ADDR_WIDTH] != rf_rptr[ADDR_WIDTH]);
   assign wf_empty = (wf_wptr == wf_rptr);
   assign wf_full  = (wf_wptr[ADDR_WIDTH-1:0] == wf_rptr[ADDR_WIDTH-1:0]) &&
                     (wf_wptr[ADDR_WIDTH] != wf_rptr[ADDR_WIDTH]);

   // Illegal requests (pop when empty, push when full) are masked here and
   // only show up in the sticky flags.
   assign rf_push = in_valid  & ~rf_full;
   assign rf_pop  = io_rden   & ~rf_empty;
   assign wf_push = io_wren   & ~wf_full;
   assign wf_pop  = out_ready & ~wf_empty;

   assign rf_wptr_nxt = rf_push ? rf_wptr + PTR_ONE : rf_wptr;
   assign rf_rptr_nxt = rf_pop  ? rf_rptr + PTR_ONE : rf_rptr;
   assign wf_wptr_nxt = wf_push ? wf_wptr + PTR_ONE : wf_wptr;
   assign wf_rptr_nxt = wf_pop  ? wf_rptr + PTR_ONE : wf_rptr;

   assign in_ready     = ~rf_full;
   assign io_read_EF   = ~rf_empty;
   assign io_read_data = rf_mem[rf_rptr[ADDR_WIDTH-1:0]];
   assign io_write_EF  = ~wf_full;
   assign out_valid    = ~wf_empty;
   assign out_data     = wf_mem[wf_rptr[ADDR_WIDTH-1:0]];

   // Control state: pointers and sticky flags. A new error event in the same
   // cycle as err_clear keeps the flag set.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rf_wptr   <= '0;
         rf_rptr   <= '0;
         wf_wptr   <= '0;
         wf_rptr   <= '0;
         underflow <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         rf_wptr   <= rf_wptr_nxt;
         rf_rptr   <= rf_rptr_nxt;
         wf_wptr   <= wf_wptr_nxt;
         wf_rptr   <= wf_rptr_nxt;
         underflow <= (io_rden & rf_empty) | (underflow & ~err_clear);
         overflow  <= (io_wren & wf_full)  | (overflow  & ~err_clear);
      end
   end

   // Storage is deliberately not reset; the empty flags hide stale words.
   always_ff @(posedge clock) begin
      if (rf_push) rf_mem[rf_wptr[ADDR_WIDTH-1:0]] <= in_data;
      if (wf_push) wf_mem[wf_wptr[ADDR_WIDTH-1:0]] <= io_write_data;
   end

`ifdef OCTAVO_IO_PORT_FIFO_COUNT_EN
   // Counts are computed from the next pointers so they change on the same
   // edge as the pointers themselves.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         read_count  <= '0;
         write_count <= '0;
      end else begin
         read_count  <= rf_wptr_nxt - rf_rptr_nxt;
         write_count <= wf_wptr_nxt - wf_rptr_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_octavo_io_port_fifo.sv
// ---------------------------------------------------------------------------
// Testbench for octavo_io_port_fifo. A queue-based reference model tracks
// both FIFOs and the sticky flags; every cycle the DUT outputs are compared
// against it, with extra directed value checks in the scripted scenarios.
// ---------------------------------------------------------------------------
module tb_octavo_io_port_fifo;
   localparam int W  = 36;
   localparam int D  = 8;
   localparam int AW = 3;

   typedef logic [W-1:0] word_t;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          in_valid;
   word_t         in_data;
   logic          in_ready;
   logic          io_read_EF;
   word_t         io_read_data;
   logic          io_rden;
   logic          io_write_EF;
   word_t         io_write_data;
   logic          io_wren;
   logic          out_valid;
   word_t         out_data;
   logic          out_ready;
   logic          err_clear;
   logic          underflow;
   logic          overflow;
`ifdef OCTAVO_IO_PORT_FIFO_COUNT_EN
   logic [AW:0]   read_count;
   logic [AW:0]   write_count;
`endif

   int total = 0;
   int bad   = 0;

   // Reference model state
   word_t rq[$];
   word_t wq[$];
   bit    uf_m, of_m;

   octavo_io_port_fifo #(.WORD_WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .in_ready      (in_ready),
      .io_read_EF    (io_read_EF),
      .io_read_data  (io_read_data),
      .io_rden       (io_rden),
      .io_write_EF   (io_write_EF),
      .io_write_data (io_write_data),
      .io_wren       (io_wren),
      .out_valid     (out_valid),
      .out_data      (out_data),
      .out_ready     (out_ready),
`ifdef OCTAVO_IO_PORT_FIFO_COUNT_EN
      .read_count    (read_count),
      .write_count   (write_count),
`endif
      .err_clear     (err_clear),
      .underflow     (underflow),
      .overflow      (overflow)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_outs();
      check("read_ef",   64'(io_read_EF),  64'(rq.size() != 0));
      check("in_ready",  64'(in_ready),    64'(rq.size() < D));
      if (rq.size() != 0) check("read_data", 64'(io_read_data), 64'(rq[0]));
      check("write_ef",  64'(io_write_EF), 64'(wq.size() < D));
      check("out_valid", 64'(out_valid),   64'(wq.size() != 0));
      if (wq.size() != 0) check("out_data", 64'(out_data), 64'(wq[0]));
      check("underflow", 64'(underflow),   64'(uf_m));
      check("overflow",  64'(overflow),    64'(of_m));
`ifdef OCTAVO_IO_PORT_FIFO_COUNT_EN
      check("read_count",  64'(read_count),  64'(rq.size()));
      check("write_count", 64'(write_count), 64'(wq.size()));
`endif
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, "_read_ef"},   64'(io_read_EF),  64'(0));
      check({tag, "_in_ready"},  64'(in_ready),    64'(1));
      check({tag, "_write_ef"},  64'(io_write_EF), 64'(1));
      check({tag, "_out_valid"}, 64'(out_valid),   64'(0));
      check({tag, "_underflow"}, 64'(underflow),   64'(0));
      check({tag, "_overflow"},  64'(overflow),    64'(0));
`ifdef OCTAVO_IO_PORT_FIFO_COUNT_EN
      check({tag, "_read_count"},  64'(read_count),  64'(0));
      check({tag, "_write_count"}, 64'(write_count), 64'(0));
`endif
   endtask

   // One clock cycle: check the model at the falling edge, drive inputs,
   // then advance the model by the FIFO rules at the rising edge.
   task automatic step(input bit iv, input word_t id, input bit rd, input bit wr,
                       input word_t wd, input bit ordy, input bit ec);
      bit r_empty, r_full, w_empty, w_full;
      @(negedge clock);
      check_outs();
      in_valid      = iv;
      in_data       = id;
      io_rden       = rd;
      io_wren       = wr;
      io_write_data = wd;
      out_ready     = ordy;
      err_clear     = ec;
      @(posedge clock);
      r_empty = (rq.size() == 0);
      r_full  = (rq.size() == D);
      w_empty = (wq.size() == 0);
      w_full  = (wq.size() == D);
      uf_m = (rd && r_empty) || (uf_m && !ec);
      of_m = (wr && w_full)  || (of_m && !ec);
      if (rd && !r_empty) void'(rq.pop_front());
      if (iv && !r_full)  rq.push_back(id);
      if (ordy && !w_empty) void'(wq.pop_front());
      if (wr && !w_full)    wq.push_back(wd);
   endtask

   task automatic idle();
      step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   function automatic word_t rnd_word();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[W-1:0];
   endfunction

   task automatic model_reset();
      rq.delete();
      wq.delete();
      uf_m = 1'b0;
      of_m = 1'b0;
   endtask

   initial begin
      bit iv, rd, wr, ordy, ec;
      in_valid = 0; in_data = '0; io_rden = 0; io_wren = 0;
      io_write_data = '0; out_ready = 0; err_clear = 0;
      model_reset();

      // Asynchronous reset with no clock edge in between
      reset_n = 1'b1;
      #2 reset_n = 1'b0;
      #1 check_reset_outs("rst_async");
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      repeat (3) idle();

      // Fill the read FIFO with 1..8, then drain it in order
      for (int k = 0; k < D; k++) step(1'b1, word_t'(k + 1), 1'b0, 1'b0, '0, 1'b0, 1'b0);
      idle();
      #1;
      check("full_in_ready", 64'(in_ready), 64'(0));
      check("full_head", 64'(io_read_data), 64'(1));
      for (int k = 0; k < D; k++) begin
         step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
         #1;
         if (k < D - 1) check("pop_seq", 64'(io_read_data), 64'(k + 2));
         else           check("pop_last_ef", 64'(io_read_EF), 64'(0));
      end
      idle();

      // Steady state at 4 entries with simultaneous push and pop
      for (int k = 0; k < 4; k++) step(1'b1, word_t'('h100 + k), 1'b0, 1'b0, '0, 1'b0, 1'b0);
      for (int k = 0; k < 20; k++) step(1'b1, word_t'('h200 + k), 1'b1, 1'b0, '0, 1'b0, 1'b0);
      idle();
      #1 check("steady_head", 64'(io_read_data), 64'('h200 + 16));
      for (int k = 0; k < 4; k++) step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      idle();

      // Underflow: set, clear, then clear and set together
      step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      idle();
      #1 check("underflow_set", 64'(underflow), 64'(1));
      step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
      idle();
      #1 check("underflow_clr", 64'(underflow), 64'(0));
      step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b1);
      idle();
      #1 check("underflow_set_wins", 64'(underflow), 64'(1));
      step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);

      // Overflow: fill the write FIFO, push 0xBAD, drain the originals
      for (int k = 0; k < D; k++) step(1'b0, '0, 1'b0, 1'b1, word_t'('h300 + k), 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1, word_t'('hBAD), 1'b0, 1'b0);
      idle();
      #1;
      check("wfull_ef", 64'(io_write_EF), 64'(0));
      check("overflow_set", 64'(overflow), 64'(1));
      for (int k = 0; k < D; k++) begin
         #1 check("drain_seq", 64'(out_data), 64'('h300 + k));
         step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
      end
      idle();
      #1 check("drain_empty", 64'(out_valid), 64'(0));
      step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);

      // Randomized traffic; many laps of both pointer sets
      for (int i = 0; i < 3000; i++) begin
         iv   = ($urandom_range(3) != 0);
         rd   = (rq.size() != 0) ? ($urandom_range(2) != 0) : ($urandom_range(49) == 0);
         wr   = (wq.size() < D)  ? ($urandom_range(2) != 0) : ($urandom_range(49) == 0);
         ordy = ($urandom_range(2) != 0);
         ec   = ($urandom_range(19) == 0);
         step(iv, rnd_word(), rd, wr, rnd_word(), ordy, ec);
      end
      for (int i = 0; i < D + 2; i++) step(1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b1);
      idle();

      // Reset mid-stream with 5 entries in each FIFO
      for (int k = 0; k < 5; k++)
         step(1'b1, word_t'('h400 + k), 1'b0, 1'b1, word_t'('h500 + k), 1'b0, 1'b0);
      idle();
      #1;
      check("pre_rst_read_ef", 64'(io_read_EF), 64'(1));
      check("pre_rst_out_valid", 64'(out_valid), 64'(1));
`ifdef OCTAVO_IO_PORT_FIFO_COUNT_EN
      check("pre_rst_read_count", 64'(read_count), 64'(5));
      check("pre_rst_write_count", 64'(write_count), 64'(5));
`endif
      @(negedge clock);
      in_valid = 1'b1; in_data = word_t'('h777);
      io_wren = 1'b1; io_write_data = word_t'('h888);
      #2 reset_n = 1'b0;
      #1 check_reset_outs("rst_mid");
      model_reset();
      @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      in_valid = 1'b0; io_wren = 1'b0;
      step(1'b1, word_t'('h123), 1'b0, 1'b1, word_t'('h456), 1'b0, 1'b0);
      idle();
      #1;
      check("post_rst_first_rd", 64'(io_read_data), 64'('h123));
      check("post_rst_first_wr", 64'(out_data), 64'('h456));
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard time bound so the run always ends
   initial begin
      #500000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/octavo_io_port_fifo.md
Name: octavo_io_port_fifo

Overview:
- Per-port buffering stage that sits directly outside one Octavo I/O port pair.
- Read side: converts an external valid/ready producer stream into the Octavo read-port signals (io_read_EF, io_read_data) and pops on io_rden.
- Write side: accepts Octavo write-port traffic (io_wren, io_write_data), advertises space on io_write_EF, and drains to an external valid/ready consumer.
- One instance per port; a top-level wrapper instantiates IO_PORT_COUNT of them.

Parameters:
- WORD_WIDTH, 36, data word width; matches the Octavo datapath word.
- DEPTH, 8, entries per FIFO (read and write FIFOs each); power of two, minimum 2.
- ADDR_WIDTH, 3, log2(DEPTH); pointers are ADDR_WIDTH+1 bits wide (wrap bit).

Ports:
- clock  in  1  single clock for all logic
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  external producer has a word
- in_data  in  WORD_WIDTH  external producer word
- in_ready  out  1  read FIFO not full
- io_read_EF  out  1  to Octavo; 1 = read FIFO non-empty (data available)
- io_read_data  out  WORD_WIDTH  to Octavo; head of read FIFO
- io_rden  in  1  from Octavo; pop read FIFO head
- io_write_EF  out  1  to Octavo; 1 = write FIFO has space
- io_write_data  in  WORD_WIDTH  from Octavo; word to enqueue
- io_wren  in  1  from Octavo; push io_write_data
- out_valid  out  1  write FIFO non-empty
- out_data  out  WORD_WIDTH  head of write FIFO
- out_ready  in  1  external consumer accepts
- err_clear  in  1  synchronous clear of sticky error flags
- underflow  out  1  sticky: io_rden seen while read FIFO empty
- overflow  out  1  sticky: io_wren seen while write FIFO full

Behaviour:
- Reset (reset_n low, asynchronous): all pointers are 0 and both flags are 0. Resulting outputs: io_read_EF=0, in_ready=1, io_write_EF=1, out_valid=0, underflow=0, overflow=0.
- Data outputs (io_read_data, out_data) are undefined while the matching FIFO is empty. Storage contents are not reset.
- Full/empty detection: empty when wr_ptr==rd_ptr. Full when the low ADDR_WIDTH bits match and the wrap bits differ.
- All status outputs are decoded from registered pointers only. There is no combinational path from any input to any output.
- Read FIFO push: in_valid & in_ready at edge N. The word is visible on io_read_data with io_read_EF=1 at N+1 if the FIFO was empty (1-cycle latency).
- Read FIFO pop: io_rden & io_read_EF at edge N advances rd_ptr. The next word, or EF=0, is presented at N+1.
- Read FIFO simultaneous push and pop, with FIFO neither empty nor full: both take effect and occupancy is unchanged. When full, in_ready=0, so the push cannot occur; the pop proceeds.
- io_rden while io_read_EF=0: no pointer change; underflow is set on the next edge.
- Write FIFO push: io_wren & io_write_EF advances wr_ptr. The word is visible on out_data with out_valid=1 at the next edge.
- io_wren while io_write_EF=0: the word is dropped, no pointer change, and overflow is set.
- Write FIFO pop: out_valid & out_ready. Simultaneous push and pop is allowed except a push when full, which is dropped per the rule above.
- Octavo contract: Octavo only asserts io_rden/io_wren for instructions whose EF check passed. underflow/overflow therefore indicate a system bug; they are never a flow-control mechanism.
- err_clear: clears both flags at the next edge. If err_clear and a new error event occur in the same cycle, the flag is set (set wins).
- Wrap-around: pointers roll over modulo 2*DEPTH. This must be exercised for at least 3 full laps.
- Reset asserted mid-transfer: FIFOs empty immediately (asynchronously) and any in-flight handshake is lost. After deassertion, the first accepted word is the first one presented.

Optional Feature:
- Macro: OCTAVO_IO_PORT_FIFO_COUNT_EN.
- Defined: adds outputs read_count and write_count, each ADDR_WIDTH+1 bits. Each equals wr_ptr-rd_ptr for its FIFO, is registered (updated the same edge as the pointers), and is 0 at reset.
- Undefined: these ports and their logic do not exist. All other behaviour is identical.

Test Plan:
- Reset then idle -> io_read_EF=0, in_ready=1, io_write_EF=1, out_valid=0, flags 0.
- Push 8 words 0x001..0x008 via in_valid with io_rden=0 -> in_ready=0 after the 8th. Then pop 8 with io_rden=1 -> io_read_data sequence 0x001..0x008, io_read_EF=0 after the last.
- Read FIFO at 4 entries, hold in_valid=1 and io_rden=1 for 20 cycles -> occupancy stays 4 and data order is preserved across a pointer wrap.
- io_rden=1 while empty -> underflow=1 next cycle. Pulse err_clear -> underflow=0. Then err_clear together with io_rden on empty -> underflow stays 1.
- Fill write FIFO with 8 io_wren (out_ready=0), then io_wren with 0xBAD -> io_write_EF=0, overflow=1. Draining out_data yields the 8 original words; 0xBAD never appears.
- Assert reset_n=0 mid-stream with 5 entries in each FIFO -> outputs return to reset values immediately, without waiting for a clock edge. With OCTAVO_IO_PORT_FIFO_COUNT_EN defined, the counts read 5 before reset and 0 after.
